acc_stack_unit: RTL and testbench
=================================

// Module: acc_stack_unit
//
// PURPOSE
//   Parametrised accumulator for the processor datapath, successor to the 12-bit AC register.
//   Holds the working value and drives both the ALU operand input and the shared bus.
//   Adds in-place ops (clear, inc/dec, shifts) and a full N/Z/C/V flag set.
//   Adds a DEPTH-entry save stack (push/pop) for nested routines.
//
// PARAMETERS
//   WIDTH  12  accumulator/data width in bits (>=4)
//   DEPTH  4   save-stack entries (>=2, power of two not required)
//
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high
//   op         in   3      accumulator op (encoding below), from control unit
//   ac_in      in   WIDTH  load value (ALU result)
//   c_in       in   1      ALU carry, captured on LOAD
//   v_in       in   1      ALU overflow, captured on LOAD
//   push       in   1      save current accumulator to stack
//   pop        in   1      restore accumulator from stack
//   err_clr    in   1      clear sticky stack_err
//   alu_out    out  WIDTH  accumulator value to ALU operand
//   bus_out    out  WIDTH  accumulator value to bus (identical to alu_out)
//   zflag      out  1      result == 0
//   nflag      out  1      result MSB
//   cflag      out  1      carry/borrow/shifted-out bit
//   vflag      out  1      signed overflow
//   stack_full out  1      sp == DEPTH
//   stack_empty out 1      sp == 0
//   stack_err  out  1      sticky: illegal push/pop attempted
//
// BEHAVIOUR
// - Reset: acc=0, alu_out=bus_out=0, all flags=0, sp=0, stack_empty=1, stack_full=0, stack_err=0.
//   Stack contents are don't-care.
// - Latency: 1 cycle. Outputs are registered and reflect the op on the next edge.
// - op: 000 NOP (hold acc and flags) | 001 LOAD acc=ac_in, C=c_in, V=v_in | 010 CLR acc=0, C=V=0
//       | 011 INC | 100 DEC | 101 SHL | 110 SHR (logical) | 111 SAR (arithmetic).
// - Flags and wrap-around (mod 2^WIDTH):
//   - Z and N are computed from the new acc on every non-NOP op and on a valid pop.
//   - INC: C=1 iff old acc all-ones (wraps to 0). V=1 iff old acc==0 followed by all ones (0x7FF->0x800).
//   - DEC: C=1 iff old acc==0 (borrow, wraps to all-ones). V=1 iff old acc==1 followed by zeros.
//   - SHL: C=old MSB, V=old MSB XOR old MSB-1.
//   - SHR/SAR: C=old LSB, V=0.
// - Push (push=1, pop=0):
//   - If sp<DEPTH: stack[sp]=acc (pre-op value), sp+1. The same-cycle op still executes.
//   - If full: no write, sp held, stack_err=1.
// - Pop (pop=1, push=0):
//   - If sp>0: acc=stack[sp-1], sp-1. Pop overrides op (op ignored).
//   - Z/N are updated from the popped value; C/V are held.
//   - If empty: acc and flags held, op ignored, stack_err=1.
// - push=1 and pop=1 together: illegal.
//   - stack_err=1; sp, acc and flags held; op ignored.
// - stack_err is sticky until reset or err_clr. If err_clr and a new error occur in the
//   same cycle, the error wins (stack_err=1).
// - stack_full/stack_empty are registered, derived from the new sp.
// - Reset has priority over all inputs, including mid push/pop.
//
// TESTING
// 1. reset -> LOAD ac_in=0x000 -> acc=0, Z=1, N=0. Then LOAD 0x800 -> Z=0, N=1.
// 2. LOAD 0xFFF; INC -> acc=0x000, Z=1, C=1, V=0. LOAD 0x7FF; INC -> 0x800, N=1, V=1.
//    DEC from 0x000 -> 0xFFF, C=1.
// 3. LOAD 0x801; SHL -> 0x002, C=1, V=1. SAR on 0x801 -> 0xC00, C=1. SHR on 0x801 -> 0x400, C=1.
// 4. Push 0x001..0x004 (DEPTH=4) -> stack_full=1. 5th push -> stack_err=1, sp=4.
//    Pop x4 -> 0x004, 0x003, 0x002, 0x001, then stack_empty=1.
// 5. Pop when empty -> acc held, stack_err=1. err_clr -> stack_err=0.
//    push+pop together -> stack_err=1, sp unchanged.
// 6. Push with op=INC on acc=0x00A -> stack top=0x00A, acc=0x00B.
//    reset asserted during a push cycle -> sp=0, acc=0.

Source files
------------

// File: rtl/acc_stack_if.sv
// acc_stack_if: control-unit side bundle of the accumulator/save-stack unit.
interface acc_stack_if #(parameter int WIDTH = 12);
  logic [2:0] op;
  logic [WIDTH-1:0] ac_in;
  logic c_in;
  logic v_in;
  logic push;
  logic pop;
  logic err_clr;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] bus_out;
  logic zflag;
  logic nflag;
  logic cflag;
  logic vflag;
  logic stack_full;
  logic stack_empty;
  logic stack_err;
  modport master (
    output op, ac_in, c_in, v_in, push, pop, err_clr,
    input alu_out, bus_out, zflag, nflag, cflag, vflag, stack_full, stack_empty, stack_err
  );
  modport slave (
    input op, ac_in, c_in, v_in, push, pop, err_clr,
    output alu_out, bus_out, zflag, nflag, cflag, vflag, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/acc_stack_unit.sv
// acc_stack_unit: accumulator with in-place ops, N/Z/C/V flags and a push/pop save stack.
module acc_stack_unit #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  acc_stack_if.slave io
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] acc_q, acc_d;
  logic z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic err_q, err_d, full_q, full_d, empty_q, empty_d;
  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic push_ok, pop_ok, err_new;
  assign sp_m1 = sp_q - 1'b1;
  assign push_ok = io.push & ~io.pop & (sp_q != SP_FULL);
  assign pop_ok = io.pop & ~io.push & (sp_q != '0);
  assign err_new = (io.push & io.pop) | (io.push & ~io.pop & (sp_q == SP_FULL)) | (io.pop & ~io.push & (sp_q == '0));
  always_comb begin
    acc_d = acc_q;
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    v_d = v_q;
    sp_d = sp_q;
    stack_d = stack_q;
    if (pop_ok) begin
      acc_d = stack_q[sp_m1[AW-1:0]];
      z_d = ~|acc_d;
      n_d = acc_d[WIDTH-1];
      sp_d = sp_m1;
    end else if (!io.pop) begin
      if (push_ok) begin
        stack_d[sp_q[AW-1:0]] = acc_q;
        sp_d = sp_q + 1'b1;
      end
      case (io.op)
        3'd1: {acc_d, c_d, v_d} = {io.ac_in, io.c_in, io.v_in};
        3'd2: {acc_d, c_d, v_d} = '0;
        3'd3: {acc_d, c_d, v_d} = {acc_q + 1'b1, &acc_q, acc_q == MAX_POS};
        3'd4: {acc_d, c_d, v_d} = {acc_q - 1'b1, acc_q == '0, acc_q == MIN_NEG};
        3'd5: {acc_d, c_d, v_d} = {acc_q[WIDTH-2:0], 1'b0, acc_q[WIDTH-1], acc_q[WIDTH-1] ^ acc_q[WIDTH-2]};
        3'd6: {acc_d, c_d, v_d} = {1'b0, acc_q[WIDTH-1:1], acc_q[0], 1'b0};
        3'd7: {acc_d, c_d, v_d} = {acc_q[WIDTH-1], acc_q[WIDTH-1:1], acc_q[0], 1'b0};
        default: ;
      endcase
      if (io.op != 3'd0) begin
        z_d = ~|acc_d;
        n_d = acc_d[WIDTH-1];
      end
    end
    err_d = err_new | (err_q & ~io.err_clr);
    full_d = sp_d == SP_FULL;
    empty_d = sp_d == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      {z_q, n_q, c_q, v_q} <= '0;
      sp_q <= '0;
      err_q <= 1'b0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      acc_q <= acc_d;
      {z_q, n_q, c_q, v_q} <= {z_d, n_d, c_d, v_d};
      sp_q <= sp_d;
      err_q <= err_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  // Stack contents are don't-care after reset, so the array needs no reset.
  always_ff @(posedge clk) stack_q <= stack_d;
  assign io.alu_out = acc_q;
  assign io.bus_out = acc_q;
  assign io.zflag = z_q;
  assign io.nflag = n_q;
  assign io.cflag = c_q;
  assign io.vflag = v_q;
  assign io.stack_full = full_q;
  assign io.stack_empty = empty_q;
  assign io.stack_err = err_q;
endmodule

// File: tb/tb_acc_stack_unit.sv
// tb_acc_stack_unit: directed vectors with hand-computed results for acc_stack_unit.
module tb_acc_stack_unit;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLR = 3'd2, INC = 3'd3, DEC = 3'd4, SHL = 3'd5, SHR = 3'd6, SAR = 3'd7;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  acc_stack_if #(.WIDTH(12)) bus ();
  acc_stack_unit #(.WIDTH(12), .DEPTH(4)) dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [2:0] op, input logic [11:0] d, input logic c, input logic v,
                     input logic pu, input logic po, input logic ec);
    bus.op = op;
    bus.ac_in = d;
    bus.c_in = c;
    bus.v_in = v;
    bus.push = pu;
    bus.pop = po;
    bus.err_clr = ec;
    @(posedge clk);
    #1;
  endtask
  task automatic op1(input logic [2:0] op, input logic [11:0] d);
    cyc(op, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  // nzcv packs {nflag, zflag, cflag, vflag}; stk packs {stack_full, stack_empty, stack_err}
  task automatic expect_st(input string tag, input logic [11:0] acc, input logic [3:0] nzcv, input logic [2:0] stk);
    check({tag, " acc"}, {20'd0, bus.alu_out}, {20'd0, acc});
    check({tag, " bus"}, {20'd0, bus.bus_out}, {20'd0, acc});
    check({tag, " nzcv"}, {28'd0, bus.nflag, bus.zflag, bus.cflag, bus.vflag}, {28'd0, nzcv});
    check({tag, " stk"}, {29'd0, bus.stack_full, bus.stack_empty, bus.stack_err}, {29'd0, stk});
  endtask
  initial begin
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("reset", 12'h000, 4'b0000, 3'b010);
    reset = 1'b0;
    op1(LOAD, 12'h000);
    expect_st("load0", 12'h000, 4'b0100, 3'b010);
    op1(LOAD, 12'h800);
    expect_st("load800", 12'h800, 4'b1000, 3'b010);
    cyc(LOAD, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("load_cv", 12'h123, 4'b0010, 3'b010);
    op1(NOP, 12'hABC);
    expect_st("nop", 12'h123, 4'b0010, 3'b010);
    op1(LOAD, 12'hFFF);
    op1(INC, 12'h000);
    expect_st("inc_wrap", 12'h000, 4'b0110, 3'b010);
    op1(LOAD, 12'h7FF);
    op1(INC, 12'h000);
    expect_st("inc_ovf", 12'h800, 4'b1001, 3'b010);
    op1(DEC, 12'h000);
    expect_st("dec_ovf", 12'h7FF, 4'b0001, 3'b010);
    op1(CLR, 12'h000);
    expect_st("clr", 12'h000, 4'b0100, 3'b010);
    op1(DEC, 12'h000);
    expect_st("dec_wrap", 12'hFFF, 4'b1010, 3'b010);
    op1(LOAD, 12'h801);
    op1(SHL, 12'h000);
    expect_st("shl", 12'h002, 4'b0011, 3'b010);
    op1(LOAD, 12'h801);
    op1(SAR, 12'h000);
    expect_st("sar", 12'hC00, 4'b1010, 3'b010);
    op1(LOAD, 12'h801);
    op1(SHR, 12'h000);
    expect_st("shr", 12'h400, 4'b0010, 3'b010);
    op1(LOAD, 12'h001);
    cyc(LOAD, 12'h002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("push1", 12'h002, 4'b0000, 3'b000);
    cyc(LOAD, 12'h003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(LOAD, 12'h004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("push4_full", 12'h004, 4'b0000, 3'b100);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("push5_err", 12'h004, 4'b0000, 3'b101);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("errclr", 12'h004, 4'b0000, 3'b100);
    cyc(LOAD, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(INC, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop4", 12'h004, 4'b0011, 3'b000);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop3", 12'h003, 4'b0011, 3'b000);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop2", 12'h002, 4'b0011, 3'b000);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop1_empty", 12'h001, 4'b0011, 3'b010);
    cyc(INC, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop_empty_err", 12'h001, 4'b0011, 3'b011);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("errclr2", 12'h001, 4'b0011, 3'b010);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_st("err_wins", 12'h001, 4'b0011, 3'b011);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    op1(LOAD, 12'h055);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("push55", 12'h055, 4'b0000, 3'b000);
    cyc(INC, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_st("pushpop_err", 12'h055, 4'b0000, 3'b001);
    cyc(CLR, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop55", 12'h055, 4'b0000, 3'b010);
    op1(LOAD, 12'h00A);
    cyc(INC, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("push_inc", 12'h00B, 4'b0000, 3'b000);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("pop_pre_op", 12'h00A, 4'b0000, 3'b010);
    cyc(NOP, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(INC, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("reset_push", 12'h000, 4'b0000, 3'b010);
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
